// File: rtl/mvau_weight_stream.sv
// Per-PE weight banks streamed in lockstep to the MVAU compute stage.
// A sequencer issues registered reads into a 2-entry output buffer; a host port reloads words live.
module mvau_weight_stream #(
    parameter int SIMD         = 2,
    parameter int PE           = 2,
    parameter int TW           = 1,
    parameter int WMEM_DEPTH   = 4,
    parameter int WMEM_ADDR_BW = 2,
    parameter     INIT_FILE    = "",
    localparam int PE_BW       = (PE > 1) ? $clog2(PE) : 1,
    localparam int WW          = SIMD * TW
) (
    input  logic                    aclk,
    input  logic                    aresetn,
    input  logic                    rewind,
    input  logic                    wr_en,
    input  logic [PE_BW-1:0]        wr_pe,
    input  logic [WMEM_ADDR_BW-1:0] wr_addr,
    input  logic [WW-1:0]           wr_data,
    output logic [PE*WW-1:0]        wmem_out,
    output logic [WMEM_ADDR_BW-1:0] wmem_addr_out,
    output logic                    wmem_last,
    output logic                    wmem_valid,
    input  logic                    wmem_ready
);

    localparam logic [WMEM_ADDR_BW-1:0] LAST_ADDR = WMEM_ADDR_BW'(WMEM_DEPTH - 1);

    logic [WMEM_ADDR_BW-1:0] rd_addr_q, rd_addr_d;
    logic [WMEM_ADDR_BW-1:0] inflight_addr_q;
    logic                    inflight_q;
    logic [1:0]              occ_q, occ_d;
    logic [PE*WW-1:0]        buf_data_q [2];
    logic [PE*WW-1:0]        buf_data_d [2];
    logic [WMEM_ADDR_BW-1:0] buf_addr_q [2];
    logic [WMEM_ADDR_BW-1:0] buf_addr_d [2];
    logic [PE*WW-1:0]        rd_data;
    logic                    pop;
    logic                    issue;
    logic                    slot;
    logic [2:0]              pending;

    assign pop = (occ_q != 2'd0) && wmem_ready;

    // Counting the slot freed by this cycle's pop keeps a steady stream at one word per cycle.
    assign pending = 3'(occ_q) + 3'(inflight_q) - 3'(pop);
    assign issue   = !rewind && (pending < 3'd2);

    // Banks carry no reset: contents survive aresetn, and writes still land while it is held.
    for (genvar gi = 0; gi < PE; gi++) begin : g_bank
        logic [WW-1:0] mem [WMEM_DEPTH];
        logic [WW-1:0] rd_q;

        always_ff @(posedge aclk) begin
            if (wr_en && (wr_pe == PE_BW'(gi))) begin
                mem[wr_addr] <= wr_data;
            end
            if (issue) begin
                rd_q <= mem[rd_addr_q];
            end
        end

        assign rd_data[gi*WW +: WW] = rd_q;
    end

    always_comb begin
        rd_addr_d = rd_addr_q;
        if (issue) begin
            rd_addr_d = (rd_addr_q == LAST_ADDR) ? '0 : rd_addr_q + 1'b1;
        end
    end

    always_comb begin
        buf_data_d = buf_data_q;
        buf_addr_d = buf_addr_q;
        slot       = (occ_q == 2'd2) || ((occ_q == 2'd1) && !pop);
        if (pop) begin
            buf_data_d[0] = buf_data_q[1];
            buf_addr_d[0] = buf_addr_q[1];
        end
        if (inflight_q) begin
            buf_data_d[slot] = rd_data;
            buf_addr_d[slot] = inflight_addr_q;
        end
        occ_d = occ_q + {1'b0, inflight_q} - {1'b0, pop};
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            rd_addr_q       <= '0;
            inflight_q      <= 1'b0;
            inflight_addr_q <= '0;
            occ_q           <= 2'd0;
            for (int i = 0; i < 2; i++) begin
                buf_data_q[i] <= '0;
                buf_addr_q[i] <= '0;
            end
        end else if (rewind) begin
            rd_addr_q  <= '0;
            inflight_q <= 1'b0;
            occ_q      <= 2'd0;
        end else begin
            rd_addr_q       <= rd_addr_d;
            inflight_q      <= issue;
            inflight_addr_q <= rd_addr_q;
            occ_q           <= occ_d;
            buf_data_q      <= buf_data_d;
            buf_addr_q      <= buf_addr_d;
        end
    end

    assign wmem_out      = buf_data_q[0];
    assign wmem_addr_out = buf_addr_q[0];
    assign wmem_last     = (buf_addr_q[0] == LAST_ADDR);
    assign wmem_valid    = (occ_q != 2'd0);

endmodule
